// File: rtl/pipe_register_file.sv
// Integer register file with two combinational read ports, one write-back port and a
// write-back scoreboard. Define RF_BYPASS_EN to forward same-cycle write-back data to the reads.
module pipe_register_file #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            hazard,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic [AW:0]     busy_cnt_q;
    logic            cnt_inc;
    logic            cnt_dec;
    logic            issue_act;
    logic            wb_act;

    assign issue_act = issue_en && (issue_rd != '0);
    assign wb_act    = wb_en && (wb_addr != '0);

    // Issue is applied after write-back so a same-cycle new producer keeps the register busy.
    always_comb begin
        busy_next = busy;
        if (wb_act)
            busy_next[wb_addr] = 1'b0;
        if (issue_act)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // The count tracks the popcount incrementally: only 0->1 and 1->0 transitions move it.
    assign cnt_inc = issue_act && !busy[issue_rd];
    assign cnt_dec = wb_act && busy[wb_addr] && !(issue_act && (issue_rd == wb_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wb_act)
                regs[wb_addr] <= wb_data;
            busy       <= busy_next;
            busy_cnt_q <= busy_cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        end
    end

    assign busy_cnt = busy_cnt_q;

`ifdef RF_BYPASS_EN
    logic byp1;
    logic byp2;

    assign byp1 = !reset && wb_act && (wb_addr == rs1_addr);
    assign byp2 = !reset && wb_act && (wb_addr == rs2_addr);

    // A same-cycle issue to the bypassed register keeps its registered busy state visible.
    assign rs1_data = (rs1_addr == '0) ? '0 : (byp1 ? wb_data : regs[rs1_addr]);
    assign rs2_data = (rs2_addr == '0) ? '0 : (byp2 ? wb_data : regs[rs2_addr]);
    assign rs1_busy = busy[rs1_addr] && !(byp1 && !(issue_en && (issue_rd == rs1_addr)));
    assign rs2_busy = busy[rs2_addr] && !(byp2 && !(issue_en && (issue_rd == rs2_addr)));
`else
    assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];
`endif

    assign hazard = rs1_busy || rs2_busy;

endmodule
